imem_fetch_arbiter: RTL and testbench
=====================================

Name: imem_fetch_arbiter

Overview:
- Shares the single combinational instruction-ROM read port (11-bit word index, 32-bit instruction) between two requesters: the CPU fetch stage and a debug/readback port.
- Arbitrates each cycle and translates the CPU byte PC into a ROM word index.
- Returns registered read data with a fixed 1-cycle latency and flags illegal fetch addresses.
- Sits between the CPU front end / debug unit and the instruction memory.

Parameters:
- ADDR_W, 11, ROM word-index width.
- DATA_W, 32, instruction width.
- BASE_ADDR, 32'h0040_0000, byte address of ROM word 0 as seen by the CPU.
- MAX_WAIT, 4, maximum consecutive cycles a requesting debug port can lose to fetch before it is forced through (range 1..15).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request.
- if_addr  in  32  fetch byte address (PC).
- if_gnt  out  1  fetch granted this cycle (combinational).
- if_rvalid  out  1  fetch data valid (registered).
- if_rdata  out  DATA_W  fetch instruction.
- if_err  out  1  registered with if_rvalid: misaligned or out-of-range fetch.
- dbg_req  in  1  debug read request.
- dbg_addr  in  ADDR_W  debug word index.
- dbg_gnt  out  1  debug granted this cycle (combinational).
- dbg_rvalid  out  1  debug data valid (registered).
- dbg_rdata  out  DATA_W  debug read data.
- imem_addr  out  ADDR_W  ROM word index.
- imem_instr  in  DATA_W  ROM combinational read data.

Behaviour:
- Reset (async, rst_n=0):
  - if_rvalid, dbg_rvalid, if_err = 0.
  - if_rdata, dbg_rdata = 0.
  - Wait counter = 0; last_addr = 0.
  - Reset asserted mid-transaction discards any response due the next cycle.
- Fetch address translation:
  - off = if_addr - BASE_ADDR, 32-bit modular subtraction.
  - Word index = off[ADDR_W+1:2].
  - misalign = (if_addr[1:0] != 0).
  - oor = (off >= 2^(ADDR_W+2)). An if_addr below BASE_ADDR wraps to a large off and is therefore oor.
- Arbitration (combinational, at most one grant per cycle):
  - Only if_req high: grant fetch.
  - Only dbg_req high: grant debug.
  - Both high: grant debug if wait_cnt == MAX_WAIT, else grant fetch.
  - Neither high: no grant.
- Wait counter (4-bit):
  - Increments, saturating at MAX_WAIT, each cycle dbg_req=1 and dbg_gnt=0.
  - Clears to 0 on dbg_gnt or dbg_req=0.
- imem_addr:
  - Driven from the granted source: translated fetch index, or dbg_addr.
  - With no grant, drives last_addr.
  - last_addr updates to imem_addr on every grant.
- Response, registered at the edge ending the grant cycle:
  - Fetch granted: if_rvalid=1; if_err = misalign|oor.
  - if_rdata = imem_instr when if_err=0; if_rdata = 32'h0000_0000 (NOP) when if_err=1.
  - Debug granted: dbg_rvalid=1, dbg_rdata = imem_instr.
  - Ungranted port: rvalid=0 next cycle; rdata holds its last value.
- Requester contract:
  - Requesters hold req and addr until they see gnt.
  - A new request may be issued in the cycle after gnt, giving one access per cycle back-to-back.
  - Address change while not granted is legal; the address sampled is the one present in the grant cycle.
- Edge cases:
  - if_err fetches still consume a grant slot and still update last_addr (truncated index).
  - A dbg request that drops before grant clears the counter and produces no response.

Test Plan:
- Reset: hold rst_n=0 with both req=1 -> all rvalid/err/rdata = 0; deassert -> first grant the next cycle.
- Fetch only, if_addr=0x0040_0008 with ROM word 2 = 0x2408_0005 -> imem_addr=2, if_gnt=1 same cycle; next cycle if_rvalid=1, if_rdata=0x2408_0005, if_err=0.
- Back-to-back fetches 0x0040_0000, 0x0040_0004, 0x0040_0008 -> if_rvalid high 3 consecutive cycles with words 0, 1, 2 in order.
- Both req held continuously, MAX_WAIT=4 -> if_gnt in cycles 0–3, dbg_gnt in cycle 4, counter back to 0; pattern repeats with 4 fetch grants then 1 debug grant.
- Fetch 0x0040_0002 -> if_err=1, if_rdata=0. Fetch 0x003F_FFFC -> if_err=1 (wrap). Fetch 0x0040_2000 -> if_err=1 (oor, ADDR_W=11).
- Debug only, dbg_addr=0x7FF -> imem_addr=0x7FF; next cycle dbg_rvalid=1, dbg_rdata=ROM[2047]. Then idle cycle -> imem_addr stays 0x7FF, both rvalid=0.

Source files
------------

// File: rtl/imem_fetch_arbiter.sv
// Arbitrates the single instruction-ROM read port between CPU fetch and debug readback.
// Fetch byte PCs are translated to ROM word indices; responses are registered (1-cycle latency).
module imem_fetch_arbiter #(
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned DATA_W    = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
  parameter int unsigned MAX_WAIT  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_instr
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

  logic [31:0]       off;
  logic [ADDR_W-1:0] fetch_idx;
  logic              misalign;
  logic              oor;
  logic              fetch_err;
  logic [3:0]        wait_cnt;
  logic [ADDR_W-1:0] last_addr;
  logic              unused_off_bits;

  // Addresses below BASE_ADDR wrap to a huge offset and land in the out-of-range check.
  assign off             = if_addr - BASE_ADDR;
  assign fetch_idx       = off[ADDR_W+1:2];
  assign misalign        = |if_addr[1:0];
  assign oor             = |off[31:ADDR_W+2];
  assign fetch_err       = misalign | oor;
  assign unused_off_bits = ^off[1:0];

  always_comb begin
    dbg_gnt   = dbg_req & (~if_req | (wait_cnt == MAX_CNT));
    if_gnt    = if_req & ~dbg_gnt;
    imem_addr = last_addr;
    if (dbg_gnt)
      imem_addr = dbg_addr;
    else if (if_gnt)
      imem_addr = fetch_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rvalid  <= 1'b0;
      if_err     <= 1'b0;
      if_rdata   <= '0;
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
      wait_cnt   <= '0;
      last_addr  <= '0;
    end else begin
      if_rvalid  <= if_gnt;
      dbg_rvalid <= dbg_gnt;
      if_err     <= if_gnt & fetch_err;
      if (if_gnt)
        if_rdata <= fetch_err ? '0 : imem_instr;
      if (dbg_gnt)
        dbg_rdata <= imem_instr;
      if (if_gnt | dbg_gnt)
        last_addr <= imem_addr;
      if (dbg_req && !dbg_gnt)
        wait_cnt <= (wait_cnt == MAX_CNT) ? wait_cnt : wait_cnt + 4'd1;
      else
        wait_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Randomized scoreboard bench for imem_fetch_arbiter: a cycle-level reference model
// predicts grants/addresses and queues expected responses; a monitor checks them.
module tb_imem_fetch_arbiter;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 32;
  localparam logic [31:0] BASE   = 32'h0040_0000;
  localparam int unsigned MAXW   = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;
  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_instr;

  logic [DATA_W-1:0] rom [2048];

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t if_q[$];
  rsp_t dbg_q[$];

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  imem_fetch_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(BASE), .MAX_WAIT(MAXW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .imem_addr(imem_addr), .imem_instr(imem_instr)
  );

  always #5 clk = ~clk;
  assign imem_instr = rom[imem_addr];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
  endtask

  // Reference model: arbitration rules applied with plain integer arithmetic.
  int          losses = 0;
  logic [31:0] m_last = 0;

  always @(negedge clk) begin
    longint off;
    int     idx;
    bit     err, win_if, win_dbg;
    logic [31:0] exp_addr;
    rsp_t   r;
    if (!rst_n) begin
      losses = 0;
      m_last = 0;
      if_q.delete();
      dbg_q.delete();
    end else begin
      off = (longint'(if_addr) - longint'(BASE) + 64'h1_0000_0000) % 64'h1_0000_0000;
      err = ((if_addr % 4) != 0) || (off >= 8192);
      idx = int'((off / 4) % 2048);
      win_dbg = dbg_req && (!if_req || losses >= int'(MAXW));
      win_if  = if_req && !win_dbg;
      if (win_dbg) exp_addr = 32'(dbg_addr);
      else if (win_if) exp_addr = 32'(idx);
      else exp_addr = m_last;
      chk("if_gnt", 32'(if_gnt), 32'(win_if));
      chk("dbg_gnt", 32'(dbg_gnt), 32'(win_dbg));
      chk("imem_addr", 32'(imem_addr), exp_addr);
      if (win_if) begin
        r.due = cyc + 1; r.err = err; r.data = err ? 32'h0 : rom[idx];
        if_q.push_back(r);
      end
      if (win_dbg) begin
        r.due = cyc + 1; r.err = 1'b0; r.data = rom[dbg_addr];
        dbg_q.push_back(r);
      end
      if (win_if || win_dbg) m_last = exp_addr;
      if (dbg_req && !win_dbg) losses = (losses + 1 > int'(MAXW)) ? int'(MAXW) : losses + 1;
      else losses = 0;
    end
  end

  // Monitor: pops expected responses when the DUT presents them.
  logic [31:0] last_if = 0;
  logic [31:0] last_dbg = 0;

  always @(negedge clk) begin
    rsp_t e;
    if (!rst_n) begin
      chk("rst_if_rvalid", 32'(if_rvalid), 32'h0);
      chk("rst_if_err", 32'(if_err), 32'h0);
      chk("rst_if_rdata", if_rdata, 32'h0);
      chk("rst_dbg_rvalid", 32'(dbg_rvalid), 32'h0);
      chk("rst_dbg_rdata", dbg_rdata, 32'h0);
      last_if = 0;
      last_dbg = 0;
    end else begin
      if (if_q.size() > 0 && if_q[0].due == cyc) begin
        e = if_q.pop_front();
        chk("if_rvalid", 32'(if_rvalid), 32'h1);
        chk("if_rdata", if_rdata, e.data);
        chk("if_err", 32'(if_err), 32'(e.err));
        last_if = e.data;
      end else begin
        chk("if_rvalid_idle", 32'(if_rvalid), 32'h0);
        chk("if_rdata_hold", if_rdata, last_if);
      end
      if (dbg_q.size() > 0 && dbg_q[0].due == cyc) begin
        e = dbg_q.pop_front();
        chk("dbg_rvalid", 32'(dbg_rvalid), 32'h1);
        chk("dbg_rdata", dbg_rdata, e.data);
        last_dbg = e.data;
      end else begin
        chk("dbg_rvalid_idle", 32'(dbg_rvalid), 32'h0);
        chk("dbg_rdata_hold", dbg_rdata, last_dbg);
      end
    end
  end

  task automatic drive(input bit ir, input logic [31:0] ia, input bit dr, input logic [ADDR_W-1:0] da);
    @(posedge clk);
    #1;
    if_req = ir; if_addr = ia; dbg_req = dr; dbg_addr = da;
  endtask

  function automatic logic [31:0] rand_pc();
    int sel = $urandom_range(0, 9);
    if (sel < 7) return BASE + ($urandom_range(0, 2047) << 2);
    else if (sel < 9) return BASE + $urandom_range(0, 8191);
    else return $urandom;
  endfunction

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = $urandom;
    rom[2] = 32'h2408_0005;
    rst_n = 1'b0;
    if_req = 1'b1; if_addr = BASE; dbg_req = 1'b1; dbg_addr = 11'h005;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    drive(1, 32'h0040_0008, 0, '0);
    drive(1, 32'h0040_0000, 0, '0);
    drive(1, 32'h0040_0004, 0, '0);
    drive(1, 32'h0040_0008, 0, '0);
    drive(0, '0, 0, '0);
    for (int i = 0; i < 12; i++) drive(1, 32'h0040_0100, 1, 11'h123);
    drive(1, 32'h0040_0002, 0, '0);
    drive(1, 32'h003F_FFFC, 0, '0);
    drive(1, 32'h0040_2000, 0, '0);
    drive(0, '0, 0, '0);
    drive(0, '0, 1, 11'h7FF);
    drive(0, '0, 0, '0);
    drive(0, '0, 0, '0);

    for (int i = 0; i < 400; i++)
      drive(($urandom % 4) != 0, rand_pc(), ($urandom % 3) == 0, 11'($urandom));

    drive(1, 32'h0040_0010, 1, 11'h055);
    drive(1, 32'h0040_0014, 1, 11'h066);
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 100; i++)
      drive(($urandom % 2) != 0, rand_pc(), ($urandom % 2) != 0, 11'($urandom));
    repeat (3) drive(0, '0, 0, '0);
    @(negedge clk);
    chk("if_q_drained", 32'(if_q.size()), 32'h0);
    chk("dbg_q_drained", 32'(dbg_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
